// File: rtl/contador_plazas_if.sv
// contador_plazas_if: debounced button levels in, occupancy/barrier/display values out.
//   master: drives btn_entrada/btn_salida, observes counter outputs.
//   slave : the counter itself.
interface contador_plazas_if #(
  parameter int ANCHO = 7
);
  logic btn_entrada;
  logic btn_salida;
  logic [ANCHO-1:0] ocupados;
  logic [ANCHO-1:0] libres;
  logic lleno;
  logic vacio;
  logic rechazo;
  logic barrera;
  logic [3:0] bcd_dec;
  logic [3:0] bcd_uni;
  modport master (
    output btn_entrada, btn_salida,
    input  ocupados, libres, lleno, vacio, rechazo, barrera, bcd_dec, bcd_uni
  );
  modport slave (
    input  btn_entrada, btn_salida,
    output ocupados, libres, lleno, vacio, rechazo, barrera, bcd_dec, bcd_uni
  );
endinterface

// File: rtl/contador_plazas.sv
// contador_plazas: parking occupancy counter with barrier-open timer and free-space digits.
//   clk_slow : 1 kHz clock
//   rst_n    : async active-low reset
//   bus      : contador_plazas_if.slave (btn_entrada/btn_salida in; ocupados, libres,
//              lleno, vacio, rechazo, barrera, bcd_dec, bcd_uni out)
//   BCD_OUT_EN defined: bcd_dec/bcd_uni carry the registered decimal split of libres;
//   otherwise they are tied to zero.
module contador_plazas #(
  parameter int CAPACIDAD = 20,
  parameter int ANCHO     = 7,
  parameter int T_BARRERA = 3000
) (
  input logic clk_slow,
  input logic rst_n,
  contador_plazas_if.slave bus
);
  localparam int TW = $clog2(T_BARRERA + 1);
  localparam logic [ANCHO-1:0] CAP = ANCHO'(CAPACIDAD);
  localparam logic [TW-1:0] T_CARGA = TW'(T_BARRERA - 1);
  typedef enum logic {REPOSO, ABIERTA} estado_t;
  estado_t estado, estado_sig;
  logic [TW-1:0] timer, timer_sig;
  logic prev_ent, prev_sal, ev_ent, ev_sal, acepta, rechaza;
  logic [ANCHO-1:0] ocupados, ocupados_sig, libres;
  logic lleno, vacio, rechazo;
  assign ev_ent = bus.btn_entrada & ~prev_ent;
  assign ev_sal = bus.btn_salida & ~prev_sal;
  // simultaneous entry+exit is always accepted, even when full or empty
  assign rechaza = (ev_ent & ~ev_sal & lleno) | (ev_sal & ~ev_ent & vacio);
  assign acepta = (ev_ent | ev_sal) & ~rechaza;
  assign ocupados_sig = (ev_ent & ~ev_sal & ~lleno) ? ocupados + 1'b1 :
                        (ev_sal & ~ev_ent & ~vacio) ? ocupados - 1'b1 : ocupados;
  always_ff @(posedge clk_slow or negedge rst_n) begin
    if (!rst_n) begin
      prev_ent <= 1'b0;
      prev_sal <= 1'b0;
      ocupados <= '0;
      libres <= CAP;
      lleno <= 1'b0;
      vacio <= 1'b1;
      rechazo <= 1'b0;
    end else begin
      prev_ent <= bus.btn_entrada;
      prev_sal <= bus.btn_salida;
      ocupados <= ocupados_sig;
      libres <= CAP - ocupados_sig;
      lleno <= ocupados_sig == CAP;
      vacio <= ocupados_sig == '0;
      rechazo <= rechaza;
    end
  end
  always_ff @(posedge clk_slow or negedge rst_n) begin
    if (!rst_n) begin
      estado <= REPOSO;
      timer <= '0;
    end else begin
      estado <= estado_sig;
      timer <= timer_sig;
    end
  end
  // timer counts T_BARRERA-1 down to 0, giving exactly T_BARRERA open cycles
  always_comb begin
    estado_sig = acepta ? ABIERTA : (estado == ABIERTA && timer == '0) ? REPOSO : estado;
    timer_sig = acepta ? T_CARGA : (estado == ABIERTA && timer != '0) ? timer - 1'b1 : timer;
  end
  assign bus.ocupados = ocupados;
  assign bus.libres = libres;
  assign bus.lleno = lleno;
  assign bus.vacio = vacio;
  assign bus.rechazo = rechazo;
  assign bus.barrera = estado == ABIERTA;
`ifdef BCD_OUT_EN
  // libres never exceeds 99, so nine conditional subtractions of 10 suffice
  function automatic logic [7:0] a_bcd(input logic [ANCHO-1:0] v);
    logic [7:0] r;
    logic [3:0] d;
    r = 8'(v);
    d = '0;
    for (int i = 0; i < 9; i++) begin
      if (r >= 8'd10) begin
        r = r - 8'd10;
        d = d + 1'b1;
      end
    end
    return {d, r[3:0]};
  endfunction
  logic [7:0] bcd;
  always_ff @(posedge clk_slow or negedge rst_n) begin
    if (!rst_n) bcd <= a_bcd(CAP);
    else bcd <= a_bcd(CAP - ocupados_sig);
  end
  assign bus.bcd_dec = bcd[7:4];
  assign bus.bcd_uni = bcd[3:0];
`else
  assign bus.bcd_dec = 4'd0;
  assign bus.bcd_uni = 4'd0;
`endif
endmodule

// File: tb/tb_contador_plazas.sv
// tb_contador_plazas: directed and randomized checks of contador_plazas against an occupancy model.
module tb_contador_plazas;
  localparam int CAP = 20;
  localparam int T = 3000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int occ, left, hi;
  bit prev_e, prev_s, rej;
  contador_plazas_if #(.ANCHO(7)) bus();
  contador_plazas #(.CAPACIDAD(CAP), .ANCHO(7), .T_BARRERA(T)) dut (
    .clk_slow(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    occ = 0;
    left = 0;
    prev_e = 0;
    prev_s = 0;
    rej = 0;
  endtask
  task automatic check_all();
    int lib;
    lib = CAP - occ;
    chk("ocupados", bus.ocupados, occ);
    chk("libres", bus.libres, lib);
    chk("lleno", bus.lleno, occ == CAP);
    chk("vacio", bus.vacio, occ == 0);
    chk("rechazo", bus.rechazo, rej);
    chk("barrera", bus.barrera, left > 0);
`ifdef BCD_OUT_EN
    chk("bcd_dec", bus.bcd_dec, lib / 10);
    chk("bcd_uni", bus.bcd_uni, lib % 10);
`else
    chk("bcd_dec", bus.bcd_dec, 0);
    chk("bcd_uni", bus.bcd_uni, 0);
`endif
  endtask
  // one clock: apply levels, advance the model on the edge, compare on the falling edge
  task automatic step(input bit ent, input bit sal);
    bit e, s;
    bus.btn_entrada = ent;
    bus.btn_salida = sal;
    @(posedge clk);
    e = ent && !prev_e;
    s = sal && !prev_s;
    prev_e = ent;
    prev_s = sal;
    rej = (e && !s && occ == CAP) || (s && !e && occ == 0);
    if (e && !s && occ < CAP) occ++;
    else if (s && !e && occ > 0) occ--;
    if ((e || s) && !rej) left = T;
    else if (left > 0) left--;
    @(negedge clk);
    check_all();
    hi += int'(bus.barrera);
  endtask
  task automatic do_reset(input bit hold_ent);
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    bus.btn_entrada = hold_ent;
    bus.btn_salida = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    bus.btn_entrada = 0;
    bus.btn_salida = 0;
    model_reset();
    @(negedge clk);
    check_all();
    @(negedge clk);
    rst_n = 1;
    step(0, 1);
    step(0, 0);
    step(0, 0);
    hi = 0;
    repeat (50) step(1, 0);
    repeat (3050) step(0, 0);
    chk("barrera_single", hi, T);
    chk("ocupados_single", bus.ocupados, 1);
    hi = 0;
    step(1, 0);
    repeat (999) step(0, 0);
    step(1, 0);
    repeat (3100) step(0, 0);
    chk("barrera_reload", hi, 4000);
    do_reset(0);
    repeat (21) begin
      step(1, 0);
      step(0, 0);
    end
    chk("fill_ocupados", bus.ocupados, CAP);
    chk("fill_libres", bus.libres, 0);
    step(1, 1);
    step(0, 0);
    chk("simul_ocupados", bus.ocupados, CAP);
    chk("simul_barrera", bus.barrera, 1);
    do_reset(0);
    repeat (7) begin
      step(1, 0);
      step(0, 0);
    end
    chk("mid_ocupados", bus.ocupados, 7);
    do_reset(1);
    step(1, 0);
    chk("edge_at_release", bus.ocupados, 1);
    for (int ph = 0; ph < 8; ph++) begin
      repeat (1500) step($urandom_range(0, 99) < (ph % 2 ? 15 : 45), $urandom_range(0, 99) < (ph % 2 ? 45 : 15));
      if (ph == 4) do_reset($urandom_range(0, 1) == 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
